// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Two-port round-robin scheduler in front of the shared ALU. Each requester
//   hands over an op and two operands on a valid/ready handshake. The sequencer
//   then walks the ALU through a fixed ISSUE / CAPTURE sequence and returns the
//   result and flag to the winning requester on a valid/ready response channel.
//   Only one operation is in flight at a time.
//
// Optional feature (compile-time macro ALU_SEQ_DIV0_GUARD_EN):
//   When defined, an accepted DIV with a zero divisor bypasses the ALU and is
//   answered directly with result 8'hFF, flag REMAINDER and rsp_err=1, one cycle
//   after acceptance. When undefined, DIV by zero goes through the ALU like any
//   other op and rsp_err is tied low.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   req_valid[1:0]/req_ready     per-port request handshake
//   req_op0/1, req_a0/1, req_b0/1 per-port operation and operands
//   rsp_valid[1:0]/rsp_ready     per-port response handshake (rsp_valid one-hot)
//   rsp_result, rsp_flag, rsp_err shared response payload
//   busy                         high whenever an operation is in progress
//   alu_op, alu_register1/2      ALU operation and operands
//   alu_enable                   ALU output enable (drives its tri-state result)
//   alu_result, alu_flag         ALU outputs
// -----------------------------------------------------------------------------

package control;
    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        MUL = 3'd3,
        DIV = 3'd4,
        AND = 3'd5,
        OR  = 3'd6,
        XOR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        ZERO      = 2'd1,
        CARRY     = 2'd2,
        REMAINDER = 2'd3
    } alu_flag_e;
endpackage

module alu_sequencer
    import control::*;
(
    input  logic        clock,
    input  logic        reset,

    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  alu_op_e     req_op0,
    input  alu_op_e     req_op1,
    input  logic [7:0]  req_a0,
    input  logic [7:0]  req_b0,
    input  logic [7:0]  req_a1,
    input  logic [7:0]  req_b1,

    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [7:0]  rsp_result,
    output alu_flag_e   rsp_flag,
    output logic        rsp_err,

    output logic        busy,

    output alu_op_e     alu_op,
    output logic [7:0]  alu_register1,
    output logic [7:0]  alu_register2,
    output logic        alu_enable,
    input  logic [7:0]  alu_result,
    input  alu_flag_e   alu_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e     state_reg;
    state_e     state_next;

    alu_op_e    op_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       grant_reg;       // port owning the in-flight operation
    logic       last_grant_reg;  // port served most recently
    logic [7:0] rsp_result_reg;
    alu_flag_e  rsp_flag_reg;

    logic       grant_valid;
    logic       grant_port;
    logic       accept;
    alu_op_e    sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic       accept_div0;

    // ------------------------------------------------------------------
    // Round-robin arbitration: a lone requester always wins; under
    // contention the port that was not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_valid = 1'b1;
                grant_port  = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_port  = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_port  = ~last_grant_reg;
            end
            default: begin
                grant_valid = 1'b0;
                grant_port  = 1'b0;
            end
        endcase
    end

    assign accept = (state_reg == IDLE) && grant_valid;
    assign sel_op = grant_port ? req_op1 : req_op0;
    assign sel_a  = grant_port ? req_a1  : req_a0;
    assign sel_b  = grant_port ? req_b1  : req_b0;

`ifdef ALU_SEQ_DIV0_GUARD_EN
    assign accept_div0 = accept && (sel_op == DIV) && (sel_b == 8'd0);
`else
    assign accept_div0 = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_div0) begin
                    state_next = RESP;
                end else if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP: begin
                // Only the owner's rsp_ready retires the response.
                if (rsp_ready[grant_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Operands and op are held through CAPTURE because the
    // ALU flag is computed combinationally from its live inputs.
    // ------------------------------------------------------------------
    always_comb begin
        busy          = (state_reg != IDLE);
        alu_op        = NOP;
        alu_register1 = 8'd0;
        alu_register2 = 8'd0;
        alu_enable    = 1'b0;
        case (state_reg)
            ISSUE: begin
                alu_op        = op_reg;
                alu_register1 = a_reg;
                alu_register2 = b_reg;
            end
            CAPTURE: begin
                alu_op        = op_reg;
                alu_register1 = a_reg;
                alu_register2 = b_reg;
                alu_enable    = 1'b1;
            end
            default: begin
                alu_enable    = 1'b0;
            end
        endcase
    end

    // Per-port handshake outputs.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi] = accept && (grant_port == 1'(gi));
        assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    end

    // ------------------------------------------------------------------
    // Request latch and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg         <= NOP;
            a_reg          <= 8'd0;
            b_reg          <= 8'd0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            rsp_result_reg <= 8'd0;
            rsp_flag_reg   <= ZERO;
        end else begin
            if (accept) begin
                op_reg         <= sel_op;
                a_reg          <= sel_a;
                b_reg          <= sel_b;
                grant_reg      <= grant_port;
                last_grant_reg <= grant_port;
            end
            if (accept_div0) begin
                rsp_result_reg <= 8'hFF;
                rsp_flag_reg   <= REMAINDER;
            end else if (state_reg == CAPTURE) begin
                rsp_result_reg <= alu_result;
                rsp_flag_reg   <= alu_flag;
            end
        end
    end

`ifdef ALU_SEQ_DIV0_GUARD_EN
    logic rsp_err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_err_reg <= 1'b0;
        end else if (accept_div0) begin
            rsp_err_reg <= 1'b1;
        end else if (state_reg == CAPTURE) begin
            rsp_err_reg <= 1'b0;
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_result = rsp_result_reg;
    assign rsp_flag   = rsp_flag_reg;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Two-port scheduler in front of the single shared `alu`. Accepts operation requests from two requesters (port 0: instruction execute path, port 1: auxiliary/microcode path) over valid/ready handshakes. Arbitrates round-robin, drives the ALU's op, operand and enable inputs through a fixed issue/capture sequence, and returns the result and flag to the winning requester over a valid/ready response channel. Only this block drives the ALU's inputs and `enable`, so the ALU's tri-stated `result` is driven only during capture.

## Interface
- No parameters. Widths are fixed at 8 bits; op/flag types are `alu_op_e`/`alu_flag_e` from package `control`.
- `clock`  in  1  system clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  2  per-port request valid
- `req_ready`  out  2  per-port request accepted this cycle
- `req_op0`, `req_op1`  in  alu_op_e  requested operation, per port
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  8 each  operands, per port
- `rsp_valid`  out  2  per-port response valid (one-hot or zero)
- `rsp_ready`  in  2  per-port response accept
- `rsp_result`  out  8  result, shared by both ports
- `rsp_flag`  out  alu_flag_e  flag, shared by both ports
- `rsp_err`  out  1  divide-by-zero trap indication (see Configuration)
- `busy`  out  1  high in any state other than IDLE
- `alu_op`  out  alu_op_e  to ALU `op`
- `alu_register1`, `alu_register2`  out  8 each  to ALU operands
- `alu_enable`  out  1  to ALU `enable`
- `alu_result`  in  8  from ALU `result`
- `alu_flag`  in  alu_flag_e  from ALU `flag`

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready[g]` is high combinationally for the granted port `g` only when `req_valid[g]` is high.
  - Grant rule: if only one port is valid, it wins. If both are valid, the port not served last wins.
  - `last_grant` resets to 1, so port 0 wins the first contention.
  - On acceptance: latch op, a and b into internal registers, record `g`, update `last_grant`, go to ISSUE.
- ISSUE:
  - Drive `alu_op`, `alu_register1` and `alu_register2` from the latched values; `alu_enable`=0.
  - The ALU registers its internal result on the closing edge. Go to CAPTURE.
- CAPTURE:
  - Hold the same op and operands (the ALU flag depends on the live op and operands); `alu_enable`=1.
  - Sample `alu_result` and `alu_flag` into the response registers at the closing edge. Go to RESP.
- RESP:
  - `rsp_valid[g]`=1; `rsp_result`, `rsp_flag` and `rsp_err` stable.
  - Hold until `rsp_ready[g]`=1, then return to IDLE. `rsp_ready` of the non-granted port is ignored.
- Outside ISSUE/CAPTURE: `alu_op`=NOP-equivalent default (value 0), operands=0, `alu_enable`=0.
- Requests that arrive while `busy` wait; they are never dropped. Operands are not sampled until acceptance.
- Only one operation is in flight; there is no overlap of response and next issue.

## Timing
- Reset values:
  - state IDLE; `req_ready`=0; `rsp_valid`=0; `rsp_result`=0; `rsp_flag`=ZERO; `rsp_err`=0.
  - `busy`=0; `alu_enable`=0; `alu_op`=0; `alu_register1`=`alu_register2`=0; `last_grant`=1.
- Latency: accept at edge N, ISSUE during N+1, CAPTURE during N+2, `rsp_valid` high from N+3.
- Throughput: at most one operation per 4 cycles, assuming immediate `rsp_ready`.
- A response accepted at edge M allows a new acceptance no earlier than edge M+1, since IDLE is re-entered first.
- Reset asserted in any state: at that edge go to IDLE and discard the in-flight operation and its response. `alu_enable` is low the following cycle.
- Simultaneous `req_valid`=2'b11 with `last_grant`=0: port 1 granted. A held request on the losing port is granted next time.

## Configuration
- `ALU_SEQ_DIV0_GUARD_EN` defined:
  - An accepted DIV with b==0 skips ISSUE/CAPTURE and goes IDLE→RESP directly; the ALU is not enabled.
  - Response: `rsp_result`=8'hFF, `rsp_flag`=REMAINDER, `rsp_err`=1. Response latency is 1 cycle after acceptance.
  - All other operations have `rsp_err`=0.
- Not defined: DIV by zero is issued to the ALU like any other operation and its output is returned unmodified. `rsp_err` is tied 0.

## Test plan
- Single op: port 0 ADD a=8'd200 b=8'd100 → `rsp_valid`=2'b01 three cycles after accept, `rsp_result`=8'd44, `rsp_flag`=CARRY.
- Contention: both ports valid from reset, port 0 SUB 9-9, port 1 OR 8'h0F|8'hF0.
  - Port 0 served first: result 0, flag ZERO.
  - Port 1 served next: result 8'hFF, flag NONE.
- Round-robin fairness: both ports hold valid for 6 ops → grants alternate 0,1,0,1,0,1; no port is starved.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles after DIV 7/2.
  - Response stays stable at result 3, flag REMAINDER; `req_ready` stays 0.
  - Release `rsp_ready` → IDLE the next cycle.
- Reset in CAPTURE: assert `reset` one cycle → no `rsp_valid`, `alu_enable`=0 next cycle, `busy`=0. A subsequent MUL 16×16 returns 0 with flag ZERO. That operation's carry is not reported, because the ZERO flag takes priority over CARRY.
- Guard: DIV 5/0.
  - With macro: `rsp_valid` one cycle after accept, result 8'hFF, flag REMAINDER, `rsp_err`=1, `alu_enable` never high.
  - Without macro: normal 3-cycle path, `rsp_err`=0.
